// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the multi-cycle divider
package div_pkg;
    localparam int DIV_W = 32;
    localparam logic [DIV_W-1:0] DIVZERO_Q = '1;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIXUP,
        DONE_Z,
        DONE
    } state_t;
endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;
    logic           w_neg;

    // The shifted remainder needs one extra bit; a borrow shows up in the top bit.
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, i_divisor};
    assign w_neg   = w_trial[WIDTH];
    assign o_rem   = w_neg ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_quo   = {i_quo[WIDTH-2:0], ~w_neg};
endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - MIPS DIV/DIVU sequencer: stall, iterate, return {HI=rem, LO=quo}
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               sign,
    input  logic               annul,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    output logic               stall_div,
    output logic               ready,
    output logic               busy,
    output logic [2*WIDTH-1:0] hilo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sign;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_hilo;
    logic               r_ready;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;

    assign w_abs_a = (r_sign & r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_abs_b = (r_sign & r_b[WIDTH-1]) ? -r_b : r_b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_rem_nx),
        .o_quo     (w_quo_nx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sign  <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_hilo  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (annul) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_a     <= opa;
                            r_b     <= opb;
                            r_sign  <= sign;
                            r_state <= (opb == '0) ? DONE_Z : PREP;
                        end
                    end
                    PREP: begin
                        r_quo   <= w_abs_a;
                        r_div   <= w_abs_b;
                        r_neg_q <= r_sign & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                        r_neg_r <= r_sign & r_a[WIDTH-1];
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_state <= ITER;
                    end
                    ITER: begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_STEP) begin
                            r_state <= FIXUP;
                        end
                    end
                    FIXUP: begin
                        r_hilo  <= {r_neg_r ? -r_rem : r_rem, r_neg_q ? -r_quo : r_quo};
                        r_ready <= 1'b1;
                        r_state <= DONE;
                    end
                    DONE_Z: begin
                        r_hilo  <= {r_a, WIDTH'(DIVZERO_Q)};
                        r_ready <= 1'b1;
                        r_state <= DONE;
                    end
                    DONE: begin
                        // start here is still the same instruction leaving E.
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Stall drops in DONE so the instruction advances on the ready cycle.
    assign stall_div = ~annul & (((r_state == IDLE) & start) |
                                 (r_state == PREP) | (r_state == ITER) |
                                 (r_state == FIXUP) | (r_state == DONE_Z));
    assign ready     = r_ready & ~annul;
    assign busy      = (r_state != IDLE);
    assign hilo      = r_hilo;
endmodule
